// File: rtl/noc_injection_arbiter_if.sv
// Bundle between the per-VC source queues, the injection arbiter and the router link,
// plus read-only debug taps of the arbiter's internal state.
interface noc_injection_arbiter_if #(
  parameter int flit_size     = 30,
  parameter int num_of_vcs    = 2,
  parameter int buffer_addr_w = 8
);
  localparam int ptr_w = (num_of_vcs > 1) ? $clog2(num_of_vcs) : 1;

  // Handshake: source flit v transfers at a rising edge where src_valid[v] & src_ready[v];
  // a source holds src_flit/src_valid steady until that edge. out_port is valid when write = 1.
  logic [num_of_vcs*flit_size-1:0]     src_flit;
  logic [num_of_vcs-1:0]               src_valid;
  logic [num_of_vcs-1:0]               src_ready;
  logic [num_of_vcs-1:0]               in_credit;
  logic [flit_size-1:0]                out_port;
  logic                                write;
  logic                                credit_err;
  logic                                busy;
  logic [ptr_w-1:0]                    dbg_rr_ptr;
  logic [num_of_vcs*buffer_addr_w-1:0] dbg_credit;
  logic                                dbg_locked;

  modport slave (
    input  src_flit, src_valid, in_credit,
    output src_ready, out_port, write, credit_err, busy,
    output dbg_rr_ptr, dbg_credit, dbg_locked
  );

  modport master (
    output src_flit, src_valid, in_credit,
    input  src_ready, out_port, write, credit_err, busy,
    input  dbg_rr_ptr, dbg_credit, dbg_locked
  );
endinterface

// File: rtl/noc_injection_arbiter.sv
// Credit-based round-robin injection scheduler from per-VC source queues onto a router link.
// Optional packet lock (no interleaving inside a packet) when INJ_PACKET_LOCK_EN is defined.
module noc_injection_arbiter #(
  parameter int flit_size     = 30,
  parameter int num_of_vcs    = 2,
  parameter int vcs_size      = 2,
  parameter int buffer_addr_w = 8,
  parameter int init_credit   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  noc_injection_arbiter_if.slave bus
);
  localparam int ptr_w = (num_of_vcs > 1) ? $clog2(num_of_vcs) : 1;
  localparam logic [buffer_addr_w-1:0] credit_init = buffer_addr_w'(init_credit);
  localparam logic [buffer_addr_w-1:0] credit_one  = buffer_addr_w'(1);
  localparam logic [buffer_addr_w-1:0] credit_max  = '1;

  logic [num_of_vcs-1:0][buffer_addr_w-1:0] credit;
  logic [ptr_w-1:0]      rr_ptr;
  logic [ptr_w-1:0]      rr_next;
  logic [num_of_vcs-1:0] eligible;
  logic [num_of_vcs-1:0] grant;
  logic [num_of_vcs-1:0] ovf;
  logic                  grant_any;
  logic [ptr_w-1:0]      grant_idx;
  int                    arb_idx;
  logic [flit_size-1:0]  sel_flit;
  logic [flit_size-1:0]  out_next;
  logic [flit_size-1:0]  out_q;
  logic                  write_q;
  logic                  err_q;

`ifdef INJ_PACKET_LOCK_EN
  localparam int tail_bit = 8;
  localparam int head_bit = 9;
  typedef enum logic {lock_idle, lock_held} lock_state_t;
  lock_state_t      lock_state;
  logic [ptr_w-1:0] lock_vc;
`endif

  // Eligibility looks only at registered credit; a same-cycle credit pulse cannot help.
  always_comb begin
    for (int v = 0; v < num_of_vcs; v++) begin
      eligible[v] = rst_n && bus.src_valid[v] && (credit[v] != '0);
`ifdef INJ_PACKET_LOCK_EN
      if (lock_state == lock_held && lock_vc != ptr_w'(v)) eligible[v] = 1'b0;
`endif
    end
  end

  always_comb begin
    grant     = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    arb_idx   = 0;
    for (int i = 0; i < num_of_vcs; i++) begin
      arb_idx = (int'(rr_ptr) + i) % num_of_vcs;
      if (!grant_any && eligible[arb_idx]) begin
        grant_any        = 1'b1;
        grant[arb_idx]   = 1'b1;
        grant_idx        = ptr_w'(arb_idx);
      end
    end
  end

  // The outgoing flit carries the VC it was actually scheduled on, whatever the source wrote.
  always_comb begin
    sel_flit = bus.src_flit[int'(grant_idx)*flit_size +: flit_size];
    out_next = sel_flit;
    out_next[vcs_size-1:0] = vcs_size'(grant_idx);
  end

  assign rr_next = ptr_w'((int'(grant_idx) + 1) % num_of_vcs);

  always_comb begin
    for (int v = 0; v < num_of_vcs; v++) begin
      ovf[v] = !grant[v] && bus.in_credit[v] && (credit[v] == credit_max);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q   <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      rr_ptr  <= '0;
      for (int v = 0; v < num_of_vcs; v++) credit[v] <= credit_init;
`ifdef INJ_PACKET_LOCK_EN
      lock_state <= lock_idle;
      lock_vc    <= '0;
`endif
    end else begin
      write_q <= grant_any;
      if (grant_any) begin
        out_q  <= out_next;
        rr_ptr <= rr_next;
      end
      if (|ovf) err_q <= 1'b1;
      for (int v = 0; v < num_of_vcs; v++) begin
        if (grant[v] && !bus.in_credit[v])
          credit[v] <= credit[v] - credit_one;
        else if (!grant[v] && bus.in_credit[v] && !ovf[v])
          credit[v] <= credit[v] + credit_one;
      end
`ifdef INJ_PACKET_LOCK_EN
      // Release happens on the tail grant itself, so another VC may win the very next cycle.
      if (grant_any) begin
        if (lock_state == lock_held) begin
          if (out_next[tail_bit]) lock_state <= lock_idle;
        end else if (out_next[head_bit] && !out_next[tail_bit]) begin
          lock_state <= lock_held;
          lock_vc    <= grant_idx;
        end
      end
`endif
    end
  end

  assign bus.src_ready  = grant;
  assign bus.busy       = |bus.src_valid;
  assign bus.out_port   = out_q;
  assign bus.write      = write_q;
  assign bus.credit_err = err_q;
  assign bus.dbg_rr_ptr = rr_ptr;
  assign bus.dbg_credit = credit;
`ifdef INJ_PACKET_LOCK_EN
  assign bus.dbg_locked = (lock_state == lock_held);
`else
  assign bus.dbg_locked = 1'b0;
`endif
endmodule

// File: tb/tb_noc_injection_arbiter.sv
// Directed + randomized bench for noc_injection_arbiter against a cycle-level reference model.
module tb_noc_injection_arbiter;
  localparam int FW   = 30;
  localparam int NV   = 2;
  localparam int VS   = 2;
  localparam int AW   = 8;
  localparam int INIT = 1;
  localparam int MAXC = (1 << AW) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  noc_injection_arbiter_if #(.flit_size(FW), .num_of_vcs(NV), .buffer_addr_w(AW)) bus ();
  noc_injection_arbiter #(.flit_size(FW), .num_of_vcs(NV), .vcs_size(VS),
                          .buffer_addr_w(AW), .init_credit(INIT))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // Narrow-counter instance used only for the saturation check.
  noc_injection_arbiter_if #(.flit_size(FW), .num_of_vcs(NV), .buffer_addr_w(1)) bus_s ();
  noc_injection_arbiter #(.flit_size(FW), .num_of_vcs(NV), .vcs_size(VS),
                          .buffer_addr_w(1), .init_credit(1))
    dut_s (.clk(clk), .rst_n(rst_n), .bus(bus_s));

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_grant = -1;

  // ---------------- reference model ----------------
  int         m_credit[NV];
  int         m_rr = 0;
  bit         m_write = 0;
  bit         m_err = 0;
  bit         m_locked = 0;
  int         m_lock_vc = 0;
  logic [FW-1:0] m_out = '0;
  logic [FW-1:0] exp_q[$];

  logic [FW-1:0] src_q[NV][$];
  int         pending[NV];
  int         obs_vc[$];
  int         obs_cyc[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [FW-1:0] make_flit(input bit head, input bit tail);
    logic [FW-1:0] f;
    f = FW'($urandom);
    f[9] = head;
    f[8] = tail;
    return f;
  endfunction

  // First valid VC with credit, scanning from the pointer; lock narrows the field to one VC.
  function automatic int model_pick();
    int v;
    if (rst_n !== 1'b1) return -1;
    for (int k = 0; k < NV; k++) begin
      v = (m_rr + k) % NV;
      if (bus.src_valid[v] && m_credit[v] > 0 && (!m_locked || v == m_lock_vc)) return v;
    end
    return -1;
  endfunction

  task automatic model_commit(input int g);
    logic [FW-1:0] f;
    int c;
    if (!rst_n) begin
      m_out = '0; m_write = 0; m_err = 0; m_rr = 0; m_locked = 0; m_lock_vc = 0;
      for (int v = 0; v < NV; v++) m_credit[v] = INIT;
      exp_q.delete();
      return;
    end
    for (int v = 0; v < NV; v++) begin
      c = m_credit[v] - ((g == v) ? 1 : 0) + (bus.in_credit[v] ? 1 : 0);
      if (c > MAXC) begin c = MAXC; m_err = 1; end
      m_credit[v] = c;
    end
    if (g >= 0) begin
      f = bus.src_flit[g*FW +: FW];
      f[VS-1:0] = VS'(g);
      m_out = f; m_write = 1; m_rr = (g + 1) % NV;
      exp_q.push_back(f);
`ifdef INJ_PACKET_LOCK_EN
      if (m_locked) begin
        if (f[8]) m_locked = 0;
      end else if (f[9] && !f[8]) begin
        m_locked = 1; m_lock_vc = g;
      end
`endif
    end else begin
      m_write = 0;
    end
  endtask

  // One cycle: inputs already driven after a negedge; check comb outputs, clock, check regs.
  task automatic step();
    int g;
    logic [NV-1:0] exp_ready;
    #1;
    g = model_pick();
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    check("src_ready", 64'(bus.src_ready), 64'(exp_ready));
    check("busy", 64'(bus.busy), 64'(|bus.src_valid));
    @(posedge clk);
    model_commit(g);
    last_grant = g;
    cyc++;
    #1;
    check("write", 64'(bus.write), 64'(m_write));
    if (m_write) check("out_port", 64'(bus.out_port), 64'(exp_q.pop_front()));
    else         check("out_port_hold", 64'(bus.out_port), 64'(m_out));
    check("credit_err", 64'(bus.credit_err), 64'(m_err));
    for (int v = 0; v < NV; v++)
      check($sformatf("credit%0d", v), 64'(bus.dbg_credit[v*AW +: AW]), 64'(m_credit[v]));
    check("rr_ptr", 64'(bus.dbg_rr_ptr), 64'(m_rr));
    @(negedge clk);
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_traffic();
    for (int v = 0; v < NV; v++) begin
      src_q[v].delete();
      pending[v] = 0;
    end
    obs_vc.delete();
    obs_cyc.delete();
    bus.src_valid = '0;
    bus.in_credit = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  // Sources present queue fronts; the router echoes one credit per write after a random delay.
  task automatic run_traffic(input int cycles, input int max_delay, input bit refill);
    for (int n = 0; n < cycles; n++) begin
      for (int v = 0; v < NV; v++) begin
        if (refill && $urandom_range(0, 3) == 0)
          src_q[v].push_back(make_flit(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))));
        if (src_q[v].size() > 0) begin
          bus.src_valid[v] = 1'b1;
          bus.src_flit[v*FW +: FW] = src_q[v][0];
        end else begin
          bus.src_valid[v] = 1'b0;
        end
        if (pending[v] > 0 && $urandom_range(0, max_delay) == 0) begin
          bus.in_credit[v] = 1'b1;
          pending[v]--;
        end else begin
          bus.in_credit[v] = 1'b0;
        end
      end
      step();
      if (last_grant >= 0) begin
        void'(src_q[last_grant].pop_front());
        pending[last_grant]++;
      end
      if (bus.write === 1'b1) begin
        obs_vc.push_back(int'(bus.out_port[VS-1:0]));
        obs_cyc.push_back(cyc);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [FW-1:0] fa, fb;
    int exp_order[6];
    for (int v = 0; v < NV; v++) m_credit[v] = INIT;
    bus.src_valid = '0; bus.src_flit = '0; bus.in_credit = '0;
    bus_s.src_valid = '0; bus_s.src_flit = '0; bus_s.in_credit = '0;
    clear_traffic();
    @(negedge clk);

    // Reset, including valid sources held during reset, then idle.
    step();
    bus.src_valid = 2'b11;
    step();
    bus.src_valid = 2'b00;
    rst_n = 1'b1;
    step();
    check("idle_write", 64'(bus.write), 64'(0));
    check("idle_out", 64'(bus.out_port), 64'(0));
    step();

    // Two flits on VC0 with no credit return until a late pulse.
    fa = make_flit(1, 1);
    fb = make_flit(1, 1);
    bus.src_valid = 2'b01;
    bus.src_flit[0 +: FW] = fa;
    step();
    check("b_first_out", 64'(bus.out_port), 64'({fa[FW-1:VS], VS'(0)}));
    bus.src_flit[0 +: FW] = fb;
    #1 check("b_stall_ready", 64'(bus.src_ready), 64'(0));
    step();
    step();
    bus.in_credit = 2'b01;
    #1 check("b_pulse_no_grant", 64'(bus.src_ready), 64'(0));
    step();
    bus.in_credit = 2'b00;
    #1 check("b_resume_ready", 64'(bus.src_ready), 64'(1));
    step();
    check("b_second_out", 64'(bus.out_port), 64'({fb[FW-1:VS], VS'(0)}));
    bus.src_valid = 2'b00;
    step();

    // Both VCs busy with immediate credit echo: alternate at full rate.
    clear_traffic();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      src_q[0].push_back(make_flit(1, 1));
      src_q[1].push_back(make_flit(1, 1));
    end
    run_traffic(12, 0, 0);
    check("c_write_count", 64'(obs_vc.size() >= 8), 64'(1));
    for (int i = 0; i < 8 && i < obs_vc.size(); i++) begin
      check($sformatf("c_order%0d", i), 64'(obs_vc[i]), 64'(i % 2));
      if (i > 0) check($sformatf("c_gap%0d", i), 64'(obs_cyc[i] - obs_cyc[i-1]), 64'(1));
    end

    // Reset while VC0 is streaming.
    clear_traffic();
    for (int i = 0; i < 6; i++) src_q[0].push_back(make_flit(1, 1));
    run_traffic(4, 0, 0);
    rst_n = 1'b0;
    step();
    check("d_write", 64'(bus.write), 64'(0));
    check("d_credit0", 64'(bus.dbg_credit[0 +: AW]), 64'(INIT));
    check("d_credit1", 64'(bus.dbg_credit[AW +: AW]), 64'(INIT));
    check("d_rr", 64'(bus.dbg_rr_ptr), 64'(0));
    rst_n = 1'b1;
    clear_traffic();
    step();

    // Same-cycle credit pulse on an empty VC, and grant + pulse on one VC.
    bus.src_valid = 2'b10;
    step();
    bus.in_credit = 2'b10;
    #1 check("e_vc1_no_same_cycle", 64'(bus.src_ready[1]), 64'(0));
    step();
    bus.src_valid = 2'b11;
    bus.in_credit = 2'b01;
    step();
    check("e_credit0_unchanged", 64'(bus.dbg_credit[0 +: AW]), 64'(INIT));
    check("e_vc0_out", 64'(bus.out_port[VS-1:0]), 64'(0));
    bus.src_valid = 2'b10;
    bus.in_credit = 2'b00;
    step();
    check("e_vc1_out", 64'(bus.out_port[VS-1:0]), 64'(1));
    bus.src_valid = 2'b00;
    step();

    // Saturation on the 1-bit counter instance.
    check("f_err_init", 64'(bus_s.credit_err), 64'(0));
    check("f_credit_init", 64'(bus_s.dbg_credit[1]), 64'(1));
    bus_s.in_credit = 2'b10;
    step();
    check("f_err_first", 64'(bus_s.credit_err), 64'(1));
    check("f_credit_sat", 64'(bus_s.dbg_credit[1]), 64'(1));
    step();
    check("f_credit_sat2", 64'(bus_s.dbg_credit[1]), 64'(1));
    bus_s.in_credit = 2'b00;
    step();
    step();
    check("f_err_sticky", 64'(bus_s.credit_err), 64'(1));

    // Three-flit packet on VC0 against single-flit packets on VC1.
    clear_traffic();
    do_reset();
    src_q[0].push_back(make_flit(1, 0));
    src_q[0].push_back(make_flit(0, 0));
    src_q[0].push_back(make_flit(0, 1));
    for (int i = 0; i < 3; i++) src_q[1].push_back(make_flit(1, 1));
`ifdef INJ_PACKET_LOCK_EN
    exp_order = '{0, 0, 0, 1, 1, 1};
`else
    exp_order = '{0, 1, 0, 1, 0, 1};
`endif
    run_traffic(14, 0, 0);
    check("g_write_count", 64'(obs_vc.size()), 64'(6));
    for (int i = 0; i < 6 && i < obs_vc.size(); i++)
      check($sformatf("g_order%0d", i), 64'(obs_vc[i]), 64'(exp_order[i]));
    if (obs_cyc.size() >= 4)
      check("g_vc1_after_tail", 64'(obs_cyc[3] - obs_cyc[2]), 64'(1));

    // Randomized traffic, then drain outstanding credits.
    clear_traffic();
    do_reset();
    run_traffic(400, 3, 1);
    for (int v = 0; v < NV; v++) src_q[v].delete();
    run_traffic(30, 0, 0);

    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/noc_injection_arbiter.md
# noc_injection_arbiter

Credit-based injection scheduler between a node's per-VC source queues and its router input link. Holds one credit counter per virtual channel and round-robin arbitrates among VC queues with a pending flit and a non-zero credit. Drives at most one flit per cycle onto the link, registered. Consumes credit pulses returned by the router.

## Interface
Parameters:
- `flit_size`, 30: flit width. VC id is in `[vcs_size-1:0]`, tail is bit 8, head is bit 9.
- `num_of_vcs`, 2: number of VCs and source queues.
- `vcs_size`, 2: width of the VC id field.
- `buffer_addr_w`, 8: credit counter width. Maximum count is `2**buffer_addr_w-1`.
- `init_credit`, 1: credit count loaded at reset. Must be ≤ the maximum count.

Ports:
- `clk`  in  1: clock. Rising edge only.
- `rst_n`  in  1: reset, synchronous, active-low.
- `src_flit`  in  num_of_vcs*flit_size: flit for VC v in slice `[v*flit_size +: flit_size]`.
- `src_valid`  in  num_of_vcs: queue v has a flit.
- `src_ready`  out  num_of_vcs: one-hot grant, combinational. Flit v is accepted at the edge where `src_valid[v] & src_ready[v]`.
- `in_credit`  in  num_of_vcs: single-cycle credit return pulse per VC.
- `out_port`  out  flit_size: flit to the router, registered.
- `write`  out  1: `out_port` is valid this cycle.
- `credit_err`  out  1: sticky flag, set on credit counter overflow.
- `busy`  out  1: OR of `src_valid`, combinational.

## Operation
- Eligibility: VC v is eligible when `src_valid[v]` is high and `credit[v] != 0`. The check uses the registered count; a same-cycle `in_credit` does not make a VC eligible.
- Arbitration: round-robin.
  - `rr_ptr` holds the index after the last granted VC.
  - The search starts at `rr_ptr` and wraps modulo num_of_vcs.
  - The first eligible VC gets `src_ready`. At most one bit is high.
  - No eligible VC means `src_ready = 0` and `rr_ptr` holds.
- On a grant to VC g:
  - `out_port` ← `src_flit[g]`, with the VC field overwritten to g.
  - `write` ← 1.
  - `credit[g]` decrements.
  - `rr_ptr` ← (g+1) mod num_of_vcs.
  - With no grant, `write` ← 0 and `out_port` holds its last value.
- Credit update per VC each cycle: next = cur − grant + `in_credit`.
  - Grant and credit pulse in the same cycle leave the count unchanged.
- Overflow: a count already at maximum that receives `in_credit` with no grant holds at maximum and sets `credit_err`. It stays set until reset.
- Underflow is impossible by construction: no grant is given at count 0.
- Reset (`rst_n` = 0 at an edge) has priority over everything, including mid-packet:
  - `out_port` = 0, `write` = 0, `credit_err` = 0.
  - `rr_ptr` = 0.
  - All credits = `init_credit`.
  - Packet lock cleared.
  - While `rst_n` is low, `src_ready` = 0.

## Timing
- Latency: a flit accepted at edge N appears on `out_port` with `write` = 1 from edge N until edge N+1. This is one registered stage with no bubbles.
- Throughput: one flit per cycle, provided credits are available.
- A credit pulse at edge N makes the VC eligible in the cycle after edge N, with its grant at edge N+1.
- With `init_credit` = 1 and the router returning credit one cycle after `write`, a single VC sustains one flit every 2 cycles. Two VCs interleave to reach full rate.

## Configuration
- `INJ_PACKET_LOCK_EN` defined:
  - Granting a flit with head=1 and tail=0 locks arbitration to that VC.
  - While locked, only the locked VC can be eligible. Other VCs get no grant even if eligible, and `rr_ptr` is not advanced by other VCs.
  - Granting a tail=1 flit on the locked VC releases the lock. The release takes effect at the same edge as the tail grant.
  - A head+tail flit (single-flit packet) never locks.
  - The lock is cleared by reset.
- `INJ_PACKET_LOCK_EN` undefined: per-flit round-robin, so packets from different VCs may interleave. The lock logic is absent.

## Test plan
- Reset, then idle: `write` = 0, `out_port` = 0, `src_ready` = 0. Two flits on VC0 with no credit return: the first goes out one cycle after acceptance, and the second stalls with `src_ready[0]` = 0 until an `in_credit[0]` pulse, then goes out 2 cycles later.
- Both VCs valid continuously, router returns credit 1 cycle after each `write`: grants alternate 0,1,0,1 with `write` high every cycle, and each `out_port` VC field matches its grant index.
- `init_credit` = 1, `buffer_addr_w` = 1, two `in_credit[1]` pulses with no traffic: the count saturates at 1 and `credit_err` goes to 1 and stays set.
- Grant and `in_credit` on VC0 in the same cycle: `credit[0]` is unchanged. A credit pulse on VC1 while it is at 0 does not grant VC1 in that same cycle.
- `rst_n` low while VC0 is mid-stream: the next cycle has `write` = 0, all credits = `init_credit`, and `rr_ptr` = 0.
- With `INJ_PACKET_LOCK_EN`: a 3-flit packet on VC0 (head, body, tail) with VC1 valid throughout: VC1 gets no grant until VC0's tail is accepted, and is granted on the next cycle.
